// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier (MUL_UNROLL bits/cycle)
// and restoring divider, sign handled by optional pre/post negation cycles.
module muldiv_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [2:0]       io_req_fn,
    input  logic [XLEN-1:0]  io_req_in1,
    input  logic [XLEN-1:0]  io_req_in2,
    input  logic [TAG_W-1:0] io_req_tag,
    input  logic             io_kill,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [XLEN-1:0]  io_resp_data,
    output logic [TAG_W-1:0] io_resp_tag
);
    typedef enum logic [2:0] {IDLE, NEG_IN, MUL, DIV, NEG_OUT, DONE} state_t;

    localparam logic [4:0] MUL_LAST = 5'(XLEN / MUL_UNROLL - 1);
    localparam logic [4:0] DIV_LAST = 5'(XLEN - 1);

    state_t             state;
    logic [2:0]         fn;
    logic [TAG_W-1:0]   tag;
    logic [2*XLEN-1:0]  a;      // mul: shifting multiplicand; div: low half is dividend/quotient
    logic [XLEN-1:0]    b;      // mul: shifting multiplier; div: divisor
    logic [2*XLEN-1:0]  acc;
    logic [XLEN:0]      rem;
    logic [4:0]         cnt;
    logic               lhs_neg, rhs_neg, neg_out;

    logic               lhs_signed, rhs_signed, lhs_neg_in, rhs_neg_in, neg_in;
    logic [2*XLEN-1:0]  mul_sum;
    logic [XLEN+1:0]    div_shift, div_diff;
    logic [XLEN:0]      rem_next;
    logic [XLEN-1:0]    res_sel;
    logic               cnt_last;

    assign io_req_ready = (state == IDLE);

    always_comb begin
        lhs_signed = (io_req_fn == 3'd1) || (io_req_fn == 3'd2) ||
                     (io_req_fn == 3'd4) || (io_req_fn == 3'd6);
        rhs_signed = (io_req_fn == 3'd1) || (io_req_fn == 3'd4) || (io_req_fn == 3'd6);
        lhs_neg_in = lhs_signed && io_req_in1[XLEN-1];
        rhs_neg_in = rhs_signed && io_req_in2[XLEN-1];
        case (io_req_fn)
            3'd1, 3'd2: neg_in = lhs_neg_in ^ rhs_neg_in;
            3'd4:       neg_in = (lhs_neg_in ^ rhs_neg_in) && (io_req_in2 != '0);
            3'd6:       neg_in = lhs_neg_in;
            default:    neg_in = 1'b0;
        endcase
    end

    always_comb begin
        mul_sum = acc;
        for (int j = 0; j < MUL_UNROLL; j++)
            if (b[j]) mul_sum = mul_sum + (a << j);
    end

    // Trial subtract one bit wider than the remainder so a zero divisor never looks negative.
    always_comb begin
        div_shift = {rem, a[XLEN-1]};
        div_diff  = div_shift - {2'b00, b};
        rem_next  = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
    end

    always_comb begin
        if (!fn[2])      res_sel = (fn == 3'd0) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
        else if (fn[1])  res_sel = rem[XLEN-1:0];
        else             res_sel = a[XLEN-1:0];
        cnt_last = (state == MUL) ? (cnt == MUL_LAST) : (cnt == DIV_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            fn            <= '0;
            tag           <= '0;
            a             <= '0;
            b             <= '0;
            acc           <= '0;
            rem           <= '0;
            cnt           <= '0;
            lhs_neg       <= 1'b0;
            rhs_neg       <= 1'b0;
            neg_out       <= 1'b0;
            io_resp_valid <= 1'b0;
            io_resp_data  <= '0;
            io_resp_tag   <= '0;
        end else if (io_kill && state != IDLE) begin
            state         <= IDLE;
            cnt           <= '0;
            io_resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (io_req_valid) begin
                    fn      <= io_req_fn;
                    tag     <= io_req_tag;
                    a       <= {{XLEN{1'b0}}, io_req_in1};
                    b       <= io_req_in2;
                    acc     <= '0;
                    rem     <= '0;
                    cnt     <= '0;
                    lhs_neg <= lhs_neg_in;
                    rhs_neg <= rhs_neg_in;
                    neg_out <= neg_in;
                    if (lhs_neg_in || rhs_neg_in) state <= NEG_IN;
                    else                          state <= io_req_fn[2] ? DIV : MUL;
                end
                NEG_IN: begin
                    if (lhs_neg) a <= {{XLEN{1'b0}}, -a[XLEN-1:0]};
                    if (rhs_neg) b <= -b;
                    state <= fn[2] ? DIV : MUL;
                end
                MUL, DIV: begin
                    if (state == MUL) begin
                        acc <= mul_sum;
                        a   <= a << MUL_UNROLL;
                        b   <= b >> MUL_UNROLL;
                    end else begin
                        rem          <= rem_next;
                        a[XLEN-1:0]  <= {a[XLEN-2:0], ~div_diff[XLEN+1]};
                    end
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= neg_out ? NEG_OUT : DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                NEG_OUT: begin
                    // Full 64-bit negate so the high half of a signed product is exact.
                    if (!fn[2])     acc         <= -acc;
                    else if (fn[1]) rem         <= {1'b0, -rem[XLEN-1:0]};
                    else            a[XLEN-1:0] <= -a[XLEN-1:0];
                    state <= DONE;
                end
                DONE: begin
                    if (!io_resp_valid) begin
                        io_resp_valid <= 1'b1;
                        io_resp_data  <= res_sel;
                        io_resp_tag   <= tag;
                    end else if (io_resp_ready) begin
                        io_resp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: results, latency, backpressure, kill and async reset.
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [2:0]  io_req_fn = '0;
    logic [31:0] io_req_in1 = '0;
    logic [31:0] io_req_in2 = '0;
    logic [4:0]  io_req_tag = '0;
    logic        io_kill = 1'b0;
    logic        io_resp_valid;
    logic        io_resp_ready = 1'b0;
    logic [31:0] io_resp_data;
    logic [4:0]  io_resp_tag;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32), .MUL_UNROLL(1), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_fn(io_req_fn), .io_req_in1(io_req_in1), .io_req_in2(io_req_in2),
        .io_req_tag(io_req_tag), .io_kill(io_kill),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_data(io_resp_data), .io_resp_tag(io_resp_tag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle.
    task automatic run_op(input string name, input logic [2:0] fn, input logic [31:0] in1,
                          input logic [31:0] in2, input logic [4:0] tg, input logic [31:0] exp,
                          input int exp_lat, input int hold);
        int n = 0;
        chk({name, "_req_ready"}, 32'(io_req_ready), 32'd1);
        io_req_valid = 1'b1;
        io_req_fn    = fn;
        io_req_in1   = in1;
        io_req_in2   = in2;
        io_req_tag   = tg;
        @(posedge clk); #1;
        io_req_valid = 1'b0;
        io_req_in1   = 32'hDEADBEEF;
        io_req_in2   = 32'h12345678;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (io_resp_valid) break;
        end
        chk({name, "_lat"}, 32'(n), 32'(exp_lat));
        chk({name, "_data"}, io_resp_data, exp);
        chk({name, "_tag"}, 32'(io_resp_tag), 32'(tg));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 32'(io_resp_valid), 32'd1);
            chk({name, "_hold_data"}, io_resp_data, exp);
            chk({name, "_hold_tag"}, 32'(io_resp_tag), 32'(tg));
            chk({name, "_hold_req_ready"}, 32'(io_req_ready), 32'd0);
        end
        io_resp_ready = 1'b1;
        @(posedge clk); #1;
        io_resp_ready = 1'b0;
        chk({name, "_idle_ready"}, 32'(io_req_ready), 32'd1);
        chk({name, "_idle_valid"}, 32'(io_resp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        #2;
        chk("rst_valid", 32'(io_resp_valid), 32'd0);
        chk("rst_data", io_resp_data, 32'd0);
        chk("rst_tag", 32'(io_resp_tag), 32'd0);
        chk("rst_req_ready", 32'(io_req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x6",      3'd0, 32'd7,        32'd6,        5'd3,  32'd42,       33, 0);
        run_op("mulhu_ff",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33, 0);
        run_op("mulh_m2x3",    3'd1, 32'hFFFFFFFE, 32'd3,        5'd5,  32'hFFFFFFFF, 35, 0);
        run_op("mulhsu_ff",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 35, 0);
        run_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 35, 0);
        run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 35, 0);
        run_op("divu_f9_2",    3'd5, 32'hFFFFFFF9, 32'd2,        5'd9,  32'h7FFFFFFC, 33, 0);
        run_op("remu_f9_2",    3'd7, 32'hFFFFFFF9, 32'd2,        5'd10, 32'd1,        33, 0);
        run_op("divu_5_0",     3'd5, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 33, 0);
        run_op("remu_5_0",     3'd7, 32'd5,        32'd0,        5'd12, 32'd5,        33, 0);
        run_op("div_5_0",      3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 33, 0);
        run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 34, 0);
        run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        35, 0);
        run_op("mul_bp",       3'd0, 32'd1000,     32'd1000,     5'd21, 32'd1000000,  33, 10);

        // Kill during the 10th DIV cycle; the result must never appear.
        io_req_valid = 1'b1; io_req_fn = 3'd5; io_req_in1 = 32'd100; io_req_in2 = 32'd7;
        io_req_tag = 5'd22;
        @(posedge clk); #1;
        io_req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 io_kill = 1'b1;
        @(posedge clk); #1;
        io_kill = 1'b0;
        chk("kill_req_ready", 32'(io_req_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (io_resp_valid) seen++;
        end
        chk("kill_no_resp", 32'(seen), 32'd0);
        run_op("mul_3x3", 3'd0, 32'd3, 32'd3, 5'd23, 32'd9, 33, 0);

        // Asynchronous reset mid-MUL: outputs clear before any clock edge.
        io_req_valid = 1'b1; io_req_fn = 3'd0; io_req_in1 = 32'd5; io_req_in2 = 32'd5;
        io_req_tag = 5'd24;
        @(posedge clk); #1;
        io_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_valid", 32'(io_resp_valid), 32'd0);
        chk("areset_data", io_resp_data, 32'd0);
        chk("areset_tag", 32'(io_resp_tag), 32'd0);
        chk("areset_req_ready", 32'(io_req_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (io_resp_valid) seen++;
        end
        chk("areset_no_resp", 32'(seen), 32'd0);
        run_op("mulhu_post", 3'd3, 32'h00010000, 32'h00030000, 5'd25, 32'd3, 33, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
